// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock through a shared N+1-bit trial subtractor.
// Define SIGNED_DIV_EN for two's-complement operands (quotient truncates toward zero).
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     r_shift_s;
  logic [N:0]     trial_s;
  logic [N-1:0]   r_iter_s;
  logic [N-1:0]   q_iter_s;
  logic [N-1:0]   dividend_mag_s;
  logic [N-1:0]   divisor_mag_s;
  logic [N-1:0]   quotient_fin_s;
  logic [N-1:0]   remainder_fin_s;

`ifdef SIGNED_DIV_EN
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
`endif

  // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore.
  always_comb begin
    r_shift_s = {r_q, q_q[N-1]};
    trial_s   = r_shift_s - {1'b0, d_q};
    if (trial_s[N] == 1'b0) begin
      r_iter_s = trial_s[N-1:0];
      q_iter_s = {q_q[N-2:0], 1'b1};
    end else begin
      r_iter_s = r_shift_s[N-1:0];
      q_iter_s = {q_q[N-2:0], 1'b0};
    end
  end

  // Operand conditioning at capture and result fix-up at completion.
  always_comb begin
`ifdef SIGNED_DIV_EN
    dividend_mag_s  = dividend[N-1] ? (~dividend + {{(N-1){1'b0}}, 1'b1}) : dividend;
    divisor_mag_s   = divisor[N-1]  ? (~divisor  + {{(N-1){1'b0}}, 1'b1}) : divisor;
    // A zero divisor forces all ones regardless of the quotient sign flag.
    if (dbz_q) begin
      quotient_fin_s = {N{1'b1}};
    end else if (sq_q) begin
      quotient_fin_s = ~q_iter_s + {{(N-1){1'b0}}, 1'b1};
    end else begin
      quotient_fin_s = q_iter_s;
    end
    remainder_fin_s = sr_q ? (~r_iter_s + {{(N-1){1'b0}}, 1'b1}) : r_iter_s;
`else
    dividend_mag_s  = dividend;
    divisor_mag_s   = divisor;
    quotient_fin_s  = q_iter_s;
    remainder_fin_s = r_iter_s;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
    sq_d        = sq_q;
    sr_d        = sr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          q_d     = dividend_mag_s;
          d_d     = divisor_mag_s;
          r_d     = {N{1'b0}};
          count_d = CW'(N - 1);
          busy_d  = 1'b1;
          dbz_d   = (divisor == {N{1'b0}});
`ifdef SIGNED_DIV_EN
          sq_d    = dividend[N-1] ^ divisor[N-1];
          sr_d    = dividend[N-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d     = r_iter_s;
        q_d     = q_iter_s;
        count_d = count_q - CW'(1);
        if (count_q == {CW{1'b0}}) begin
          state_d     = IDLE;
          quotient_d  = quotient_fin_s;
          remainder_d = remainder_fin_s;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= {N{1'b0}};
      q_q         <= {N{1'b0}};
      d_q         <= {N{1'b0}};
      count_q     <= {CW{1'b0}};
      quotient_q  <= {N{1'b0}};
      remainder_q <= {N{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
`ifdef SIGNED_DIV_EN
      sq_q        <= sq_d;
      sr_q        <= sr_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus back-to-back and mid-operation reset sequences.
module tb_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int edges;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b;
    check({nm, "_busy"}, int'(busy), 1);
    wait_done(edges);
    check({nm, "_latency"}, edges, N);
    check({nm, "_q"}, int'(quotient), int'(eq));
    check({nm, "_r"}, int'(remainder), int'(er));
    check({nm, "_dbz"}, int'(div_by_zero), int'(ez));
    check({nm, "_busy_end"}, int'(busy), 0);
    @(posedge clk); #1;
    check({nm, "_done_1cyc"}, int'(done), 0);
    check({nm, "_q_held"}, int'(quotient), int'(eq));
  endtask

  initial begin
    int edges;
    int done_seen;

`ifdef SIGNED_DIV_EN
    vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});  // -7/2
    vecs.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});  // 7/-2
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});  // -128/-1 wraps
    vecs.push_back('{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0});  // -7/-2
    vecs.push_back('{8'hDB, 8'h00, 8'hFF, 8'hDB, 1'b1});  // -37/0
    vecs.push_back('{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1});  // -128/0
    vecs.push_back('{8'd37, 8'd0,  8'hFF, 8'd37, 1'b1});
    vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2,  1'b0});
`else
    vecs.push_back('{8'd200, 8'd7,  8'd28,  8'd4,  1'b0});
    vecs.push_back('{8'd37,  8'd0,  8'hFF,  8'd37, 1'b1});
    vecs.push_back('{8'd5,   8'd9,  8'd0,   8'd5,  1'b0});
    vecs.push_back('{8'hFF,  8'd1,  8'hFF,  8'd0,  1'b0});
    vecs.push_back('{8'hFF,  8'hFF, 8'd1,   8'd0,  1'b0});
    vecs.push_back('{8'd0,   8'd5,  8'd0,   8'd0,  1'b0});
    vecs.push_back('{8'd128, 8'd2,  8'd64,  8'd0,  1'b0});
    vecs.push_back('{8'd254, 8'd255, 8'd0,  8'd254, 1'b0});
`endif

    // Reset state
    #12;
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Back-to-back: start pulses while busy are ignored, start in done cycle is accepted
    @(negedge clk);
    dividend = 8'd255; divisor = 8'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    wait_done(edges);
    check("b2b_first_latency", edges, N - 3);
`ifdef SIGNED_DIV_EN
    check("b2b_first_q", int'(quotient), 8'd0);
    check("b2b_first_r", int'(remainder), 8'hFF);
`else
    check("b2b_first_q", int'(quotient), 15);
    check("b2b_first_r", int'(remainder), 15);
`endif
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd77; divisor = 8'd0;
    check("b2b_done_drop", int'(done), 0);
    check("b2b_busy2", int'(busy), 1);
`ifdef SIGNED_DIV_EN
    check("b2b_old_q_held", int'(quotient), 8'd0);
`else
    check("b2b_old_q_held", int'(quotient), 15);
`endif
    wait_done(edges);
    check("b2b_second_latency", edges, N);
    check("b2b_second_q", int'(quotient), 3);
    check("b2b_second_r", int'(remainder), 0);
    check("b2b_second_dbz", int'(div_by_zero), 0);

    // Mid-operation reset aborts without a done
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", int'(quotient), 0);
    check("mid_rst_r", int'(remainder), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_idle_busy", int'(busy), 0);
    run_div("after_rst", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
